class_tree_sched: RTL and testbench



---
 rtl/class_tree_sched.sv | 126 ++++++++++++
 tb/tb_class_tree_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/class_tree_sched.sv
// class_tree_sched: one-vs-rest ensemble scheduler that walks every
// (class, tree) pair through one shared tree port, counts the trees that
// fire for each class, and returns the argmax class.
//   in_valid/in_ready/in_feat     : feature vector handshake
//   ev_feat/ev_class/ev_tree      : registered vector and pair select to the tree bank
//   ev_bit                        : selected tree output, combinational from ev_*
//   out_valid/out_ready           : result handshake
//   out_class/out_votes/out_tie   : winning class, its vote count, tie flag
// Optional build macro TREE_OUT_REG_EN registers ev_bit before accumulation
// and adds a one-cycle DRAIN state.
module class_tree_sched #(
    parameter int N_FEAT  = 51,
    parameter int N_CLASS = 5,
    parameter int N_TREE  = 4,
    parameter int CW      = $clog2(N_CLASS),
    parameter int TW      = (N_TREE > 1) ? $clog2(N_TREE) : 1,
    parameter int VW      = $clog2(N_TREE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic [N_FEAT-1:0] ev_feat,
    output logic [CW-1:0]     ev_class,
    output logic [TW-1:0]     ev_tree,
    input  logic              ev_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_class,
    output logic [VW-1:0]     out_votes,
    output logic              out_tie
);
    typedef enum logic [2:0] {IDLE, EVAL, DRAIN, DECIDE, OUT} state_t;
    state_t state, next;
    logic [VW-1:0] votes [N_CLASS];
    logic          last_tree, last_pair, acc_en, acc_bit, best_tie;
    logic [CW-1:0] acc_class, best_class;
    logic [VW-1:0] best_votes;
    int            n_max;

    assign last_tree = ev_tree == TW'(N_TREE - 1);
    assign last_pair = last_tree && ev_class == CW'(N_CLASS - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;

`ifdef TREE_OUT_REG_EN
    // The vote lands one cycle after its pair was presented; pend_q marks
    // that the registered bit belongs to a real EVAL cycle.
    logic          bit_q, pend_q;
    logic [CW-1:0] class_q;
    always_ff @(posedge clk) begin
        bit_q   <= ev_bit;
        class_q <= ev_class;
        pend_q  <= !rst && state == EVAL;
    end
    assign acc_en    = pend_q;
    assign acc_bit   = bit_q;
    assign acc_class = class_q;
`else
    assign acc_en    = state == EVAL;
    assign acc_bit   = ev_bit;
    assign acc_class = ev_class;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? EVAL : IDLE;
`ifdef TREE_OUT_REG_EN
            EVAL:    next = last_pair ? DRAIN : EVAL;
`else
            EVAL:    next = last_pair ? DECIDE : EVAL;
`endif
            DRAIN:   next = DECIDE;
            DECIDE:  next = OUT;
            OUT:     next = out_ready ? IDLE : OUT;
            default: next = IDLE;
        endcase
    end

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        best_class = '0;
        best_votes = '0;
        n_max      = 0;
        for (int c = 0; c < N_CLASS; c++)
            if (votes[c] > best_votes) begin
                best_votes = votes[c];
                best_class = CW'(c);
            end
        for (int c = 0; c < N_CLASS; c++)
            if (votes[c] == best_votes) n_max++;
        best_tie = n_max > 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ev_feat   <= '0;
            ev_class  <= '0;
            ev_tree   <= '0;
            out_class <= '0;
            out_votes <= '0;
            out_tie   <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) votes[c] <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                ev_feat <= in_feat;
                for (int c = 0; c < N_CLASS; c++) votes[c] <= '0;
            end else if (acc_en) begin
                votes[acc_class] <= votes[acc_class] + VW'(acc_bit);
            end
            if (state == EVAL) begin
                ev_tree  <= last_tree ? '0 : ev_tree + 1'b1;
                ev_class <= last_pair ? '0 : last_tree ? ev_class + 1'b1 : ev_class;
            end
            if (state == DECIDE) begin
                out_class <= best_class;
                out_votes <= best_votes;
                out_tie   <= best_tie;
            end
        end
    end
endmodule

// File: tb/tb_class_tree_sched.sv
// tb_class_tree_sched: randomized self-checking bench for class_tree_sched
// with a stub tree bank driven from a per-pair fire pattern.
module tb_class_tree_sched;
    localparam int N_FEAT  = 51;
    localparam int N_CLASS = 5;
    localparam int N_TREE  = 4;
    localparam int CW      = $clog2(N_CLASS);
    localparam int TW      = (N_TREE > 1) ? $clog2(N_TREE) : 1;
    localparam int VW      = $clog2(N_TREE + 1);
    localparam int N       = N_CLASS * N_TREE;
`ifdef TREE_OUT_REG_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic              clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic              in_ready, ev_bit, out_valid, out_tie;
    logic [N_FEAT-1:0] in_feat = '0, ev_feat;
    logic [CW-1:0]     ev_class, out_class;
    logic [TW-1:0]     ev_tree;
    logic [VW-1:0]     out_votes;
    logic [N-1:0]      fire = '0;
    int                vec = 0, err = 0;

    class_tree_sched #(.N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .N_TREE(N_TREE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .ev_feat(ev_feat), .ev_class(ev_class), .ev_tree(ev_tree),
        .ev_bit(ev_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_votes(out_votes), .out_tie(out_tie)
    );

    always #5 clk = ~clk;

    // Stub tree bank: pair (c, t) fires when fire[c*N_TREE+t] is set.
    assign ev_bit = fire[int'(ev_class) * N_TREE + int'(ev_tree)];

    function automatic logic [N_FEAT-1:0] rand_feat();
        return {$urandom, $urandom};
    endfunction

    // Reference: count fired trees per class, pick the first maximum.
    function automatic void model(input logic [N-1:0] pat, output int cls, output int votes, output bit tie);
        int v [N_CLASS];
        int hits;
        votes = 0;
        cls   = 0;
        hits  = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            v[c] = 0;
            for (int t = 0; t < N_TREE; t++) v[c] += int'(pat[c * N_TREE + t]);
            if (v[c] > votes) begin
                votes = v[c];
                cls   = c;
            end
        end
        for (int c = 0; c < N_CLASS; c++) if (v[c] == votes) hits++;
        tie = hits > 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        vec++; if (in_ready !== 1'b1)  begin err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        vec++; if ({ev_class, ev_tree, out_class, out_votes, out_tie} !== '0)
            begin err++; $display("FAIL reset indices/outputs got %h want 0", {ev_class, ev_tree, out_class, out_votes, out_tie}); end
        vec++; if (ev_feat !== '0) begin err++; $display("FAIL reset ev_feat got %h want 0", ev_feat); end
    endtask

    // One classification: checks pair order, ev_feat stability, latency,
    // result, backpressure hold and release. mid_pulse re-asserts in_valid
    // during EVAL with a different vector, which must be ignored.
    task automatic run_vec(input string name, input logic [N-1:0] pat, input int hold, input bit mid_pulse);
        logic [N_FEAT-1:0] feat;
        int e_cls, e_votes, lat, seq_bad;
        bit e_tie;
        logic [CW-1:0] h_cls;
        logic [VW-1:0] h_votes;
        logic h_tie;
        model(pat, e_cls, e_votes, e_tie);
        fire      = pat;
        feat      = rand_feat();
        in_feat   = feat;
        in_valid  = 1;
        out_ready = (hold == 0);
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL %s start in_ready got %b want 1", name, in_ready); end
        tick();
        in_valid = 0;
        in_feat  = rand_feat();
        seq_bad  = 0;
        for (int k = 0; k < N; k++) begin
            if (int'(ev_class) != k / N_TREE || int'(ev_tree) != k % N_TREE || ev_feat !== feat || in_ready !== 1'b0) begin
                if (seq_bad == 0)
                    $display("FAIL %s sequence step %0d got (%0d,%0d) feat %h want (%0d,%0d) feat %h", name, k,
                             ev_class, ev_tree, ev_feat, k / N_TREE, k % N_TREE, feat);
                seq_bad++;
            end
            in_valid = mid_pulse && k == 5;
            tick();
        end
        in_valid = 0;
        vec++; if (seq_bad != 0) err++;
        vec++; if ({ev_class, ev_tree} !== '0 || ev_feat !== feat)
            begin err++; $display("FAIL %s post-eval idx/feat got (%0d,%0d) %h want (0,0) %h", name, ev_class, ev_tree, ev_feat, feat); end
        lat = N + 1;
        while (out_valid !== 1'b1 && lat < N + 10) begin
            tick();
            lat++;
        end
        vec++; if (lat != LAT) begin err++; $display("FAIL %s latency got %0d want %0d", name, lat, LAT); end
        vec++; if (int'(out_class) != e_cls || int'(out_votes) != e_votes || out_tie !== e_tie)
            begin err++; $display("FAIL %s result got class %0d votes %0d tie %b want class %0d votes %0d tie %b",
                                  name, out_class, out_votes, out_tie, e_cls, e_votes, e_tie); end
        h_cls   = out_class;
        h_votes = out_votes;
        h_tie   = out_tie;
        for (int i = 0; i < hold; i++) begin
            tick();
            vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== h_cls || out_votes !== h_votes || out_tie !== h_tie)
                begin err++; $display("FAIL %s hold cycle %0d got valid %b ready %b class %0d votes %0d want held", name, i,
                                      out_valid, in_ready, out_class, out_votes); end
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin err++; $display("FAIL %s release got valid %b ready %b want 0 1", name, out_valid, in_ready); end
        vec++; if (ev_feat !== feat) begin err++; $display("FAIL %s ev_feat after got %h want %h", name, ev_feat, feat); end
    endtask

    task automatic test_directed();
        logic [N-1:0] p;
        p = '0;
        for (int t = 0; t < N_TREE; t++) p[3 * N_TREE + t] = 1'b1;
        run_vec("class3", p, 0, 1'b0);
        p = '0;
        p[1 * N_TREE + 0] = 1'b1; p[1 * N_TREE + 1] = 1'b1;
        p[4 * N_TREE + 0] = 1'b1; p[4 * N_TREE + 1] = 1'b1;
        run_vec("tie14", p, 0, 1'b0);
        run_vec("none", '0, 0, 1'b0);
        run_vec("all", '1, 0, 1'b0);
    endtask

    task automatic test_sequencing();
        run_vec("mid_pulse", N'({$urandom, $urandom}), 0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_vec("backpressure", N'({$urandom, $urandom}), 10, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        for (int i = 0; i < 12; i++) begin
            p = N'({$urandom, $urandom}) & N'({$urandom, $urandom});
            run_vec("random", p, int'($urandom_range(0, 3)), 1'(i % 2));
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] p;
        fire     = '1;
        in_feat  = rand_feat();
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin err++; $display("FAIL midrst handshake got ready %b valid %b want 1 0", in_ready, out_valid); end
        vec++; if ({ev_class, ev_tree, out_class, out_votes, out_tie} !== '0 || ev_feat !== '0)
            begin err++; $display("FAIL midrst state got %h feat %h want 0", {ev_class, ev_tree, out_class, out_votes, out_tie}, ev_feat); end
        p = '0;
        p[2 * N_TREE + 0] = 1'b1;
        run_vec("after_reset", p, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_sequencing();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
